// File: rtl/gpio_wb_arbiter_pkg.sv
// gpio_wb_arbiter_pkg: shared arbiter state encoding, default bus widths and timeout counter width helper
package gpio_wb_arbiter_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 1;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/gpio_wb_arbiter_if.sv
// gpio_wb_arbiter_if: Wishbone link (adr, dat_w, dat_r, sel, we, stb, cyc, ack, err); master drives the request, slave returns dat_r/ack/err
interface gpio_wb_arbiter_if
  import gpio_wb_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic [1:0] sel;
  logic we;
  logic stb;
  logic cyc;
  logic ack;
  logic err;
  modport master(output adr, dat_w, sel, we, stb, cyc, input dat_r, ack, err);
  modport slave(input adr, dat_w, sel, we, stb, cyc, output dat_r, ack, err);
endinterface

// File: rtl/gpio_wb_arb_timer.sv
// gpio_wb_arb_timer: stalled-strobe counter; ports wb_clk_i, wb_rst_ni, start (count this cycle), clr, expire (count reached TIMEOUT)
module gpio_wb_arb_timer
  import gpio_wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic start,
  input  logic clr,
  output logic expire
);
  localparam int CW = cnt_w(TIMEOUT);
  logic [CW-1:0] cnt;
  assign expire = cnt == CW'(TIMEOUT);
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) cnt <= '0;
    else cnt <= (clr || expire) ? '0 : start ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/gpio_wb_arbiter.sv
// gpio_wb_arbiter: round-robin two-master Wishbone arbiter for the GPIO slave; ports wb_clk_i, wb_rst_ni, m0/m1 (slave side), s (master side), gnt_o; GPIO_WB_ARBITER_TIMEOUT_EN adds the ack timeout
module gpio_wb_arbiter
  import gpio_wb_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  gpio_wb_arbiter_if.slave  m0,
  gpio_wb_arbiter_if.slave  m1,
  gpio_wb_arbiter_if.master s,
  output logic [1:0] gnt_o
);
  state_t state, state_n;
  logic last, g0, g1, stb, expire;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= IDLE;
      last <= 1'b1;
    end else begin
      state <= state_n;
      last <= (g0 && !m0.cyc) ? 1'b0 : (g1 && !m1.cyc) ? 1'b1 : last;
    end
  always_comb begin
    state_n = state;
    case (state)
      GNT0: state_n = m0.cyc ? GNT0 : m1.cyc ? GNT1 : IDLE;
      GNT1: state_n = m1.cyc ? GNT1 : m0.cyc ? GNT0 : IDLE;
      default: state_n = (m0.cyc && (!m1.cyc || last)) ? GNT0 : m1.cyc ? GNT1 : IDLE;
    endcase
  end
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gnt_o = {g1, g0};
  assign stb = g0 ? m0.stb : g1 & m1.stb;
  assign s.cyc = g0 ? m0.cyc : g1 & m1.cyc;
  assign s.stb = stb & ~expire;
  assign s.we = g0 ? m0.we : g1 & m1.we;
  assign s.adr = g0 ? m0.adr : g1 ? m1.adr : {AW{1'b0}};
  assign s.dat_w = g0 ? m0.dat_w : g1 ? m1.dat_w : {DW{1'b0}};
  assign s.sel = g0 ? m0.sel : g1 ? m1.sel : 2'b00;
  assign m0.ack = g0 & s.ack;
  assign m1.ack = g1 & s.ack;
  assign m0.dat_r = g0 ? s.dat_r : {DW{1'b0}};
  assign m1.dat_r = g1 ? s.dat_r : {DW{1'b0}};
  assign m0.err = g0 & expire;
  assign m1.err = g1 & expire;
`ifdef GPIO_WB_ARBITER_TIMEOUT_EN
  gpio_wb_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .wb_clk_i(wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .start(stb & ~s.ack),
    .clr(state == IDLE || state != state_n || s.ack),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
endmodule

// File: doc/gpio_wb_arbiter.md
Name: gpio_wb_arbiter

Overview:
Two-master Wishbone arbiter that shares the single GPIO slave port (1-bit address, 16-bit data, LEDs/switches) between the CPU bus (m0) and a secondary master (m1, e.g. a debug/monitor unit).
- Round-robin grant, held for the whole bus cycle (cyc_i high).
- Slave signals are muxed from the granted master; ack/data are returned only to that master.
- Sits between the masters and the GPIO slave in the top-level interconnect.

Parameters:
DW, 16, data bus width
AW, 1, address width (GPIO register select)
TIMEOUT, 15, max cycles a strobed access may wait for ack (used only with the optional feature)

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  asynchronous active-low reset
m0_adr_i  in  AW  master 0 address
m0_dat_i  in  DW  master 0 write data
m0_dat_o  out  DW  master 0 read data
m0_sel_i  in  2  master 0 byte select
m0_we_i  in  1  master 0 write enable
m0_stb_i  in  1  master 0 strobe
m0_cyc_i  in  1  master 0 cycle
m0_ack_o  out  1  master 0 ack
m0_err_o  out  1  master 0 error (timeout)
m1_*  same set as m0_*, for master 1
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_dat_i  in  DW  slave read data
s_sel_o  out  2  slave byte select
s_we_o  out  1  slave write enable
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_ack_i  in  1  slave ack
gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle

Behaviour:
- FSM states: IDLE, GNT0, GNT1; state is registered. Reset (wb_rst_ni low, asynchronous):
  - state = IDLE, last = 1 (so m0 wins first), timeout counter = 0.
  - All outputs 0: s_cyc_o, s_stb_o, s_we_o, m*_ack_o, m*_err_o, gnt_o; m*_dat_o = 0.
- IDLE:
  - Only m0_cyc_i high -> GNT0; only m1_cyc_i high -> GNT1.
  - Both high -> grant the master that is not 'last'.
  - Neither -> stay in IDLE.
- GNT0 (GNT1 symmetric):
  - s_cyc_o = m0_cyc_i, s_stb_o = m0_stb_i; s_adr_o/s_dat_o/s_sel_o/s_we_o = m0 values.
  - m0_ack_o = s_ack_i, m0_dat_o = s_dat_i (combinational pass-through).
  - m1_ack_o = 0 and m1_dat_o = 0 while not granted.
- In IDLE the slave sees all-zero control (s_cyc_o = s_stb_o = s_we_o = 0), so there are no stray writes.
- Grant latency:
  - Master raises cyc/stb in cycle N; grant is registered at edge N+1.
  - Slave strobed in cycle N+1; the GPIO slave acks combinationally, so ack reaches the master in cycle N+1.
- Release: the granted master drops cyc_i; at the next edge last = that master, then:
  - other master's cyc_i high -> hand over directly (GNT0 -> GNT1); no idle bubble.
  - otherwise -> IDLE.
- Grant is never pre-empted while the holder's cyc_i stays high (bursts/RMW are atomic).
- stb_i low with cyc_i high: the grant is held and the slave is not strobed.
- Reset mid-cycle: immediate return to IDLE; both outputs drop asynchronously, with no ack/err glitch.

Optional Feature:
Macro GPIO_WB_ARBITER_TIMEOUT_EN.
- Enabled:
  - A counter increments every cycle that s_stb_o is high and s_ack_i is low; it clears on ack, on grant change and in IDLE.
  - When the count reaches TIMEOUT, the granted master's err_o pulses for 1 cycle, s_stb_o is forced low for that cycle and the counter clears.
  - The grant is held until that master drops cyc_i.
- Disabled: no counter is instantiated; m0_err_o and m1_err_o are tied to 0.

Decomposition:
- Package gpio_wb_arbiter_pkg: state enum {IDLE, GNT0, GNT1}, DW/AW defaults, and a TIMEOUT counter-width function (clog2(TIMEOUT+1)).
- One natural sub-module, gpio_wb_arb_timer (timeout counter with start/clear/expire), instantiated only under the macro.
- Arbiter FSM and muxing stay in the top module.

Test Plan:
- Reset release, no requests -> gnt_o=00, s_cyc_o=0, all acks 0 for 10 cycles.
- m0 writes adr=1 dat=16'h00A5 sel=2'b01 -> gnt_o=01 next cycle, s_we_o=1, s_dat_o=16'h00A5, m0_ack_o=1 same cycle; m1_ack_o stays 0.
- m0 and m1 both raise cyc in the same cycle after reset -> m0 granted first; on m0 cyc drop -> gnt_o=10 at the next edge with no idle cycle; next simultaneous request -> m0 granted (last=m1).
- m1 holds cyc for a 4-access burst while m0 requests -> gnt_o stays 10 for all 4 acks; m0 granted only after m1 drops cyc.
- m1 reads adr=0 with s_dat_i=16'h003C -> m1_dat_o=16'h003C with ack; m0_dat_o=0.
- TIMEOUT_EN, TIMEOUT=15, s_ack_i held 0 -> m0_err_o pulses exactly once, 15 cycles after the strobe starts; without the macro err stays 0 and stb stays high indefinitely.
- Assert wb_rst_ni low mid-access -> gnt_o=00 and s_cyc_o=0 immediately, without waiting for a clock edge.
